// File: rtl/mmix_dmem_bridge.sv
`default_nettype none
// mmix_dmem_bridge: MMIX execute-stage load/store port to a 32-bit big-endian Avalon-MM master.
// Aligns by access size, splits octas into two tetra transfers, returns zero-extended read data.
module mmix_dmem_bridge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [63:0]       mem_address,
  input  logic [1:0]        mem_datasize,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [63:0]       mem_writedata,
  output logic [63:0]       mem_readdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  localparam logic [1:0] S_IDLE = 2'd0, S_ACC1 = 2'd1, S_ACC2 = 2'd2, S_DONE = 2'd3;
  localparam logic [1:0] SZ_BYTE = 2'd0, SZ_WYDE = 2'd1, SZ_TETRA = 2'd2, SZ_OCTA = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              write_q, write_d;
  logic [31:0]       wlo_q, wlo_d;
  logic [31:0]       hi_q, hi_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              req;
  logic              xfer_ok;
  logic [2:0]        low_mask;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_be;
  logic [31:0]       req_wdata;
  logic [31:0]       lane;
  logic              unused_addr_bits;

  assign req      = mem_read | mem_write;
  assign xfer_ok  = ~avm_waitrequest;
  assign low_mask = 3'((4'd1 << mem_datasize) - 4'd1);
  assign req_addr = {mem_address[ADDR_W-1:3], mem_address[2:0] & ~low_mask};
  assign unused_addr_bits = ^mem_address[63:ADDR_W];

  // Request-side lane steering; byteenable bit 3 is the lowest byte address.
  always_comb begin
    req_be    = 4'b1111;
    req_wdata = mem_writedata[31:0];
    case (mem_datasize)
      SZ_BYTE: begin
        req_be    = 4'b1000 >> req_addr[1:0];
        req_wdata = {4{mem_writedata[7:0]}};
      end
      SZ_WYDE: begin
        req_be    = req_addr[1] ? 4'b0011 : 4'b1100;
        req_wdata = {2{mem_writedata[15:0]}};
      end
      SZ_TETRA: req_wdata = mem_writedata[31:0];
      default:  req_wdata = mem_writedata[63:32];
    endcase
  end

  always_comb begin
    lane = avm_readdata;
    case (size_q)
      SZ_BYTE: lane = {24'h0, 8'(avm_readdata >> {~off_q, 3'b000})};
      SZ_WYDE: lane = off_q[1] ? {16'h0, avm_readdata[15:0]} : {16'h0, avm_readdata[31:16]};
      default: lane = avm_readdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      size_q  <= 2'd0;
      off_q   <= 2'd0;
      write_q <= 1'b0;
      wlo_q   <= 32'h0;
      hi_q    <= 32'h0;
      rdata_q <= 64'h0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'h0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      off_q   <= off_d;
      write_q <= write_d;
      wlo_q   <= wlo_d;
      hi_q    <= hi_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  // Requests seen in DONE are the requester's stale ones and are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_ACC1;
      S_ACC1:  if (xfer_ok) state_d = (size_q == SZ_OCTA) ? S_ACC2 : S_DONE;
      S_ACC2:  if (xfer_ok) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    size_d  = size_q;
    off_d   = off_q;
    write_d = write_q;
    wlo_d   = wlo_q;
    hi_d    = hi_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    addr_d  = addr_q;
    be_d    = be_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          size_d  = mem_datasize;
          off_d   = req_addr[1:0];
          write_d = mem_write;
          wlo_d   = mem_writedata[31:0];
          addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          be_d    = req_be;
          wdata_d = req_wdata;
          rd_d    = ~mem_write;
          wr_d    = mem_write;
        end
      end
      S_ACC1: begin
        if (xfer_ok) begin
          if (size_q == SZ_OCTA) begin
            // Strobes stay up: the low tetra follows with no idle gap.
            addr_d  = addr_q + ADDR_W'(4);
            wdata_d = wlo_q;
            if (!write_q) hi_d = avm_readdata;
          end else begin
            rd_d   = 1'b0;
            wr_d   = 1'b0;
            done_d = 1'b1;
            if (!write_q) rdata_d = {32'h0, lane};
          end
        end
      end
      S_ACC2: begin
        if (xfer_ok) begin
          rd_d   = 1'b0;
          wr_d   = 1'b0;
          done_d = 1'b1;
          if (!write_q) rdata_d = {hi_q, avm_readdata};
        end
      end
      default: ;
    endcase
  end

  assign mem_readdata   = rdata_q;
  assign mem_done       = done_q;
  assign avm_address    = addr_q;
  assign avm_byteenable = be_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mmix_dmem_bridge.sv
`default_nettype none
// tb_mmix_dmem_bridge: directed tests of the MMIX data-memory bridge against a simple Avalon slave.
module tb_mmix_dmem_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] mem_address;
  logic [1:0]  mem_datasize;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_writedata;
  logic [63:0] mem_readdata;
  logic        mem_done;
  logic [31:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  logic [31:0] rd_mem [0:15];

  int checks = 0;
  int failures = 0;

  int          lat;
  int          nx;
  int          unstable;
  logic        done_after;
  logic [63:0] rdout;
  logic [31:0] xa  [0:3];
  logic [3:0]  xbe [0:3];
  logic [31:0] xd  [0:3];
  logic        xw  [0:3];

  mmix_dmem_bridge #(.ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_address(mem_address), .mem_datasize(mem_datasize),
    .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_done(mem_done),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  assign avm_readdata = rd_mem[avm_address[5:2]];

  // Issue one request at a negedge (cycle C), play the slave, and log bus transfers until mem_done.
  task automatic do_access(input logic wr, input logic [1:0] sz, input logic [63:0] addr,
                           input logic [63:0] wd, input int waits);
    int   wl;
    logic have_snap;
    logic [69:0] snap;
    @(negedge clk);
    mem_read = ~wr; mem_write = wr; mem_datasize = sz; mem_address = addr; mem_writedata = wd;
    lat = 0; nx = 0; unstable = 0; wl = waits; have_snap = 1'b0; snap = '0; rdout = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (mem_done) begin
        lat = k;
        rdout = mem_readdata;
        break;
      end
      if (avm_read || avm_write) begin
        if (have_snap && snap !== {avm_address, avm_byteenable, avm_writedata, avm_read, avm_write})
          unstable++;
        if (wl > 0) begin
          avm_waitrequest = 1'b1;
          wl--;
          if (!have_snap) begin
            snap = {avm_address, avm_byteenable, avm_writedata, avm_read, avm_write};
            have_snap = 1'b1;
          end
        end else begin
          avm_waitrequest = 1'b0;
          have_snap = 1'b0;
          if (nx < 4) begin
            xa[nx] = avm_address; xbe[nx] = avm_byteenable; xd[nx] = avm_writedata; xw[nx] = avm_write;
          end
          nx++;
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0; avm_waitrequest = 1'b0;
    @(negedge clk);
    done_after = mem_done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_datasize = 2'd0;
    mem_address = '0; mem_writedata = '0; avm_waitrequest = 1'b0;
    rd_mem[0] = 32'h11223344; rd_mem[1] = 32'hCAFEF00D;
    rd_mem[2] = 32'h01234567; rd_mem[3] = 32'h89ABCDEF;
    for (int i = 4; i < 16; i++) rd_mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    checks++; if (mem_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", mem_done); end
    checks++; if (avm_read !== 1'b0) begin failures++; $display("FAIL rst_read got=%b exp=0", avm_read); end
    checks++; if (avm_write !== 1'b0) begin failures++; $display("FAIL rst_write got=%b exp=0", avm_write); end
    checks++; if (avm_byteenable !== 4'h0) begin failures++; $display("FAIL rst_be got=%b exp=0000", avm_byteenable); end
    checks++; if (avm_address !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", avm_address); end
    checks++; if (avm_writedata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", avm_writedata); end
    checks++; if (mem_readdata !== 64'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", mem_readdata); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ldb();
    do_access(1'b0, 2'd0, 64'h1003, 64'h0, 0);
    checks++; if (lat !== 2) begin failures++; $display("FAIL ldb_latency got=%0d exp=2", lat); end
    checks++; if (nx !== 1) begin failures++; $display("FAIL ldb_xfers got=%0d exp=1", nx); end
    checks++; if (xa[0] !== 32'h1000) begin failures++; $display("FAIL ldb_addr got=%h exp=00001000", xa[0]); end
    checks++; if (xbe[0] !== 4'b0001) begin failures++; $display("FAIL ldb_be got=%b exp=0001", xbe[0]); end
    checks++; if (xw[0] !== 1'b0) begin failures++; $display("FAIL ldb_dir got=%b exp=0", xw[0]); end
    checks++; if (rdout !== 64'h44) begin failures++; $display("FAIL ldb_data got=%h exp=44", rdout); end
    checks++; if (done_after !== 1'b0) begin failures++; $display("FAIL ldb_done_pulse got=%b exp=0", done_after); end
  endtask

  task automatic test_load_lanes();
    do_access(1'b0, 2'd0, 64'hFFFF_0000_0000_1000, 64'h0, 0);
    checks++; if (xbe[0] !== 4'b1000 || xa[0] !== 32'h1000) begin failures++;
      $display("FAIL ldb0_bus got=%h/%b exp=00001000/1000", xa[0], xbe[0]); end
    checks++; if (rdout !== 64'h11) begin failures++; $display("FAIL ldb0_data got=%h exp=11", rdout); end
    do_access(1'b0, 2'd1, 64'h1003, 64'h0, 0);
    checks++; if (xbe[0] !== 4'b0011) begin failures++; $display("FAIL ldw_be got=%b exp=0011", xbe[0]); end
    checks++; if (rdout !== 64'h3344) begin failures++; $display("FAIL ldw_data got=%h exp=3344", rdout); end
    do_access(1'b0, 2'd2, 64'h1006, 64'h0, 0);
    checks++; if (xa[0] !== 32'h1004 || xbe[0] !== 4'b1111) begin failures++;
      $display("FAIL ldt_bus got=%h/%b exp=00001004/1111", xa[0], xbe[0]); end
    checks++; if (rdout !== 64'hCAFEF00D) begin failures++; $display("FAIL ldt_data got=%h exp=cafef00d", rdout); end
  endtask

  task automatic test_ldo();
    do_access(1'b0, 2'd3, 64'h100D, 64'h0, 0);
    checks++; if (lat !== 3) begin failures++; $display("FAIL ldo_latency got=%0d exp=3", lat); end
    checks++; if (nx !== 2) begin failures++; $display("FAIL ldo_xfers got=%0d exp=2", nx); end
    checks++; if (xa[0] !== 32'h1008 || xa[1] !== 32'h100C) begin failures++;
      $display("FAIL ldo_addr got=%h,%h exp=00001008,0000100c", xa[0], xa[1]); end
    checks++; if (xbe[0] !== 4'b1111 || xbe[1] !== 4'b1111) begin failures++;
      $display("FAIL ldo_be got=%b,%b exp=1111,1111", xbe[0], xbe[1]); end
    checks++; if (rdout !== 64'h0123456789ABCDEF) begin failures++;
      $display("FAIL ldo_data got=%h exp=0123456789abcdef", rdout); end
  endtask

  task automatic test_stores();
    do_access(1'b1, 2'd1, 64'h1001, 64'hFFFFBEEF, 0);
    checks++; if (lat !== 2) begin failures++; $display("FAIL stw_latency got=%0d exp=2", lat); end
    checks++; if (nx !== 1 || xw[0] !== 1'b1) begin failures++; $display("FAIL stw_xfers got=%0d/%b exp=1/1", nx, xw[0]); end
    checks++; if (xa[0] !== 32'h1000) begin failures++; $display("FAIL stw_addr got=%h exp=00001000", xa[0]); end
    checks++; if (xbe[0] !== 4'b1100) begin failures++; $display("FAIL stw_be got=%b exp=1100", xbe[0]); end
    checks++; if (xd[0] !== 32'hBEEFBEEF) begin failures++; $display("FAIL stw_wdata got=%h exp=beefbeef", xd[0]); end
    checks++; if (mem_readdata !== 64'h0123456789ABCDEF) begin failures++;
      $display("FAIL stw_rdata_hold got=%h exp=0123456789abcdef", mem_readdata); end
    do_access(1'b1, 2'd0, 64'h1002, 64'h1234_005A, 0);
    checks++; if (xbe[0] !== 4'b0010 || xd[0] !== 32'h5A5A5A5A) begin failures++;
      $display("FAIL stb_lane got=%b/%h exp=0010/5a5a5a5a", xbe[0], xd[0]); end
  endtask

  task automatic test_sto_wait();
    do_access(1'b1, 2'd3, 64'h2000, 64'hAABBCCDD11223344, 3);
    checks++; if (lat !== 6) begin failures++; $display("FAIL sto_latency got=%0d exp=6", lat); end
    checks++; if (unstable !== 0) begin failures++; $display("FAIL sto_stable got=%0d exp=0", unstable); end
    checks++; if (nx !== 2) begin failures++; $display("FAIL sto_xfers got=%0d exp=2", nx); end
    checks++; if (xa[0] !== 32'h2000 || xd[0] !== 32'hAABBCCDD) begin failures++;
      $display("FAIL sto_word0 got=%h:%h exp=00002000:aabbccdd", xa[0], xd[0]); end
    checks++; if (xa[1] !== 32'h2004 || xd[1] !== 32'h11223344 || xw[1] !== 1'b1) begin failures++;
      $display("FAIL sto_word1 got=%h:%h:%b exp=00002004:11223344:1", xa[1], xd[1], xw[1]); end
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; mem_datasize = 2'd0; mem_address = 64'h1003;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_done) begin k = i; break; end
    end
    checks++; if (k !== 2) begin failures++; $display("FAIL b2b_first_done got=%0d exp=2", k); end
    @(negedge clk);
    checks++; if (avm_read !== 1'b0 || mem_done !== 1'b0) begin failures++;
      $display("FAIL b2b_no_reaccess got=%b/%b exp=0/0", avm_read, mem_done); end
    mem_datasize = 2'd2; mem_address = 64'h1004;
    @(negedge clk);
    checks++; if (avm_read !== 1'b1 || avm_address !== 32'h1004) begin failures++;
      $display("FAIL b2b_accept got=%b/%h exp=1/00001004", avm_read, avm_address); end
    @(negedge clk);
    checks++; if (mem_done !== 1'b1 || mem_readdata !== 64'hCAFEF00D) begin failures++;
      $display("FAIL b2b_second got=%b/%h exp=1/cafef00d", mem_done, mem_readdata); end
    mem_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int bad;
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; mem_datasize = 2'd3; mem_address = 64'h1008;
    @(negedge clk);
    @(negedge clk);
    checks++; if (avm_read !== 1'b1 || avm_address !== 32'h100C) begin failures++;
      $display("FAIL rmid_acc2 got=%b/%h exp=1/0000100c", avm_read, avm_address); end
    reset_n = 1'b0;
    #1;
    checks++; if (avm_read !== 1'b0 || mem_done !== 1'b0) begin failures++;
      $display("FAIL rmid_strobe got=%b/%b exp=0/0", avm_read, mem_done); end
    checks++; if (mem_readdata !== 64'h0) begin failures++; $display("FAIL rmid_rdata got=%h exp=0", mem_readdata); end
    mem_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_done || avm_read || avm_write) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rmid_quiet got=%0d exp=0", bad); end
    do_access(1'b0, 2'd0, 64'h1003, 64'h0, 0);
    checks++; if (lat !== 2 || rdout !== 64'h44) begin failures++;
      $display("FAIL rmid_recover got=%0d/%h exp=2/44", lat, rdout); end
  endtask

  initial begin
    test_reset();
    test_ldb();
    test_load_lanes();
    test_ldo();
    test_stores();
    test_sto_wait();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmix_dmem_bridge.md
# mmix_dmem_bridge

Data-memory bridge between the MMIX execute stage's load/store port and a 32-bit Avalon-MM master interface toward on-board memory. It accepts one byte/wyde/tetra/octa request at a time, aligns the address per MMIX rules and splits octas into two big-endian tetra transfers. It steers byte lanes and returns right-justified, zero-extended read data with a one-cycle `mem_done` pulse. Sign extension and overflow checks stay in the execute stage.

## Interface
- `ADDR_W`, 32: bus byte-address width; `mem_address[ADDR_W-1:0]` is used, upper bits are ignored.
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `mem_address` in 64: MMIX byte address.
- `mem_datasize` in 2: 0 byte, 1 wyde, 2 tetra, 3 octa.
- `mem_read` in 1: read request level.
- `mem_write` in 1: write request level; wins if both are high.
- `mem_writedata` in 64: store data; low-order `8<<size` bits are stored.
- `mem_readdata` out 64: load result, right-justified and zero-extended.
- `mem_done` out 1: one-cycle completion pulse.
- `avm_address` out ADDR_W: word-aligned bus byte address (bits [1:0]=0).
- `avm_byteenable` out 4: bit 3 = bits [31:24] = lowest byte address.
- `avm_read` out 1: bus read strobe.
- `avm_write` out 1: bus write strobe.
- `avm_writedata` out 32: bus write data.
- `avm_readdata` in 32: bus read data, valid in the cycle the read completes.
- `avm_waitrequest` in 1: slave stall.

## Operation
- States: IDLE, ACC1, ACC2, DONE. All outputs are registered.
- IDLE: if `mem_read|mem_write`, latch address, size, data and direction, then go to ACC1. Otherwise stay in IDLE.
- Alignment: `A = mem_address & ~((1<<size)-1)`. `o = A[1:0]`.
- ACC1 bus address:
  - Octa: `A & ~7` (high tetra).
  - Other sizes: `A & ~3`.
- Byte enables:
  - Byte: `4'b1000 >> o`.
  - Wyde: `1100` if `o=0`, `0011` if `o=2`.
  - Tetra and octa: `1111`.
- Write data lanes:
  - Byte: `{4{d[7:0]}}`.
  - Wyde: `{2{d[15:0]}}`.
  - Tetra: `d[31:0]`.
  - Octa: ACC1 sends `d[63:32]`, ACC2 sends `d[31:0]`.
- A transfer completes in the first ACC cycle with `avm_waitrequest=0`. Strobe, address, byteenable and writedata are held stable until then.
- ACC1 complete:
  - Octa goes to ACC2 with address +4.
  - Other sizes go to DONE.
  - On a read, capture the lane:
    - Byte: `rd[31-8o -: 8]`.
    - Wyde: `rd[31-8o -: 16]`.
    - Tetra: `rd`.
    - Octa: high word.
- ACC2 complete: capture the low word and go to DONE.
- DONE: `mem_done=1` and `mem_readdata` valid; return to IDLE. The request lines are ignored in DONE, because the requester still holds its old request in this cycle.
- `mem_readdata` holds its value until the next read completes. Writes leave it unchanged.

## Timing
- Reset: state IDLE. `mem_done`, `avm_read`, `avm_write`, `avm_byteenable`, `avm_address`, `avm_writedata` and `mem_readdata` are all 0.
- Zero-wait latency, counted from the request-sampled cycle C:
  - Single transfer: strobe in C+1, `mem_done` in C+2.
  - Octa: strobes in C+1 and C+2, `mem_done` in C+3.
- Each `avm_waitrequest` cycle adds one cycle.
- The earliest next request is sampled in DONE+1. Back-to-back single accesses therefore cost 3 cycles each.
- Strobes deassert in the cycle after completion. There is no idle gap between ACC1 and ACC2.
- Reset mid-operation: the bus strobes drop immediately, state goes to IDLE, and no `mem_done` is issued. The requester is reset by the same net.

## Test plan
- LDB, `mem_address=0x1003`, word@0x1000=`0x11223344`, no waits -> `avm_byteenable=0001`, `mem_readdata=0x44`, `mem_done` at C+2.
- LDO, `mem_address=0x100D`, words@0x1008=`0x01234567`, @0x100C=`0x89ABCDEF` -> reads 0x1008 then 0x100C, `mem_readdata=0x0123456789ABCDEF`, done at C+3.
- STW, `mem_address=0x1001`, `mem_writedata=0xFFFFBEEF` -> `avm_address=0x1000`, byteenable `1100`, writedata `0xBEEFBEEF`, single write.
- STO at 0x2000, data `0xAABBCCDD11223344`, `avm_waitrequest` high 3 cycles on the first word -> address/data held stable, done at C+6, then low word `0x11223344` written at 0x2004.
- Request held through DONE -> no second bus access; a new LDT presented in DONE+1 is accepted in DONE+1.
- `reset_n` pulsed low during ACC2 of an octa read -> `avm_read`=0 and state IDLE immediately, `mem_done` never pulses, `mem_readdata`=0.
